// File: rtl/csr_ctrl_pkg.sv
// Shared definitions for the CSR access sequencer: FSM states, CSR op
// encodings and the read-only address field value.
package csr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } csr_state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // addr[11:10] value that marks a read-only CSR
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

endpackage

// File: rtl/csr_access_ctrl_illegal_chk.sv
// Combinational legality check for a CSR instruction.
// Build option: CSR_RO_CHECK_EN -- when defined, any write attempt to a
// read-only CSR (addr[11:10] == 2'b11) is flagged illegal; when undefined
// the check is disabled and illegal is always 0.
module csr_illegal_chk
  import csr_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [11:0] addr,
  input  logic        src_zero,
  output logic        illegal
);

  // Address bits below the read-only field never affect legality.
  logic unused_bits;

`ifdef CSR_RO_CHECK_EN
  // rw always writes; rs/rc write only when the operand is non-zero.
  assign illegal     = (addr[11:10] == CSR_RO_FIELD) && ((op == OP_RW) || !src_zero);
  assign unused_bits = ^addr[9:0];
`else
  assign illegal     = 1'b0;
  assign unused_bits = ^{op, addr, src_zero};
`endif

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: accepts one CSR instruction at a time, reads the
// addressed CSR, issues at most one rw/rs/rc strobe and returns the old
// value. Privileged trap updates are granted only while idle.
// Build option: CSR_RO_CHECK_EN (see csr_illegal_chk) enables read-only
// CSR write detection and rsp_illegal reporting.
module csr_access_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [11:0]   req_addr,
  input  logic [DW-1:0] req_src,
  input  logic [5:0]    req_tag,
  input  logic          trap_valid,
  output logic          trap_grant,
  input  logic          flush,
  output logic [11:0]   csr_addr,
  output logic [DW-1:0] csr_op,
  output logic          csr_rw,
  output logic          csr_rs,
  output logic          csr_rc,
  input  logic [DW-1:0] csr_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [5:0]    rsp_tag,
  output logic          rsp_illegal
);

  csr_state_t    state_q, state_d;
  logic [1:0]    op_q;
  logic [11:0]   addr_q;
  logic [DW-1:0] src_q;
  logic [5:0]    tag_q;
  logic [DW-1:0] data_q;
  logic          ill_q;

  logic          accept;
  logic          src_zero;
  logic          illegal;
  logic          skip;

  assign accept   = (state_q == IDLE) && req_valid && req_ready;
  assign src_zero = (src_q == '0);
  assign skip     = illegal || ((op_q != OP_RW) && src_zero);

  csr_illegal_chk u_illegal_chk (
    .op       (op_q),
    .addr     (addr_q),
    .src_zero (src_zero),
    .illegal  (illegal)
  );

  // Latched instruction drives the array port directly; results are held in
  // registers so they stay stable under response backpressure.
  assign csr_addr    = addr_q;
  assign csr_op      = src_q;
  assign rsp_data    = data_q;
  assign rsp_tag     = tag_q;
  assign rsp_illegal = ill_q;

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Instruction latch on accept; read value and legality captured in READ
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op_q   <= OP_RW;
      addr_q <= '0;
      src_q  <= '0;
      tag_q  <= '0;
      data_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        src_q  <= req_src;
        tag_q  <= req_tag;
      end
      if (state_q == READ) begin
        data_q <= csr_rdata;
        ill_q  <= illegal;
      end
    end
  end

  // Next-state, handshake and strobe decode
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    trap_grant = 1'b0;
    csr_rw     = 1'b0;
    csr_rs     = 1'b0;
    csr_rc     = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        trap_grant = trap_valid;
        req_ready  = !trap_valid && !flush;
        if (req_valid && req_ready) state_d = READ;
      end
      READ: begin
        if (flush)     state_d = IDLE;
        else if (skip) state_d = RESP;
        else           state_d = WRITE;
      end
      WRITE: begin
        csr_rw  = !flush && (op_q == OP_RW);
        csr_rs  = !flush && (op_q == OP_RS);
        csr_rc  = !flush && (op_q == OP_RC);
        state_d = flush ? IDLE : RESP;
      end
      RESP: begin
        // A flush in RESP suppresses the handshake entirely
        rsp_valid = !flush;
        if (flush || rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
